wm8731_cfg_sequencer: RTL

- Power-up configuration controller for the WM8731 codec that feeds the I2S record/play datapath.
- On `start`, writes a fixed 7-entry register table to the codec over a 2-wire I2C bus. The bus master is bit-banged with a quarter-period tick.
- Reports `busy`, `done` and `ack_error`. The top FSM holds I2S start until `done` is high.

---
 rtl/wm8731_cfg_sequencer.sv | 237 +++++++++++++++++++++++
 1 files changed

// File: rtl/wm8731_cfg_sequencer.sv
// wm8731_cfg_sequencer
// Power-up configuration controller for the WM8731 codec. On start it writes a
// fixed 7-entry register table over a bit-banged 2-wire bus. The bus uses a
// quarter-bit tick, so the SCL period is 4*CLK_DIV clk cycles.
//
// Ports:
//   clk, rst_n   system clock, asynchronous active-low reset
//   start        single-cycle pulse; launches the sequence when not busy
//   i2c_sclk     SCL, push-pull
//   i2c_sda_oe   1 = pull SDA low, 0 = release it
//   i2c_sda_in   SDA pin level (asynchronous, synchronised internally)
//   busy         high from launch until done or error
//   done         level; all 7 commands written
//   ack_error    level; a command exhausted its retries
//   cmd_idx      current or last command index
//
// Build option WM8731_CFG_ACK_CHECK_EN: when defined, ACK slots are checked
// and NACKed commands are retried up to MAX_RETRY times before ERROR. When
// undefined, every transaction counts as ACKed and ack_error stays 0.
module wm8731_cfg_sequencer #(
    parameter int unsigned CLK_DIV   = 4,
    parameter int unsigned MAX_RETRY = 3,
    parameter logic [6:0]  DEV_ADDR  = 7'h1A
) (
    input  logic       clk,
    input  logic       rst_n,
    input  logic       start,
    output logic       i2c_sclk,
    output logic       i2c_sda_oe,
    input  logic       i2c_sda_in,
    output logic       busy,
    output logic       done,
    output logic       ack_error,
    output logic [2:0] cmd_idx
);

    typedef enum logic [2:0] {
        S_IDLE, S_START, S_BIT, S_STOP, S_GAP, S_DONE
`ifdef WM8731_CFG_ACK_CHECK_EN
        , S_ERROR
`endif
    } state_e;

    state_e      state_q, state_d;
    logic [1:0]  qtr_q, qtr_d;
    logic [4:0]  slot_q, slot_d;
    logic [2:0]  cmd_q, cmd_d;
    logic [11:0] div_q, div_d;
    logic        sclk_q, sclk_d;
    logic        oe_q, oe_d;
    logic        active, tick, acked;

    function automatic logic [15:0] rom(input logic [2:0] i);
        case (i)
            3'd0:    rom = 16'h1E00;
            3'd1:    rom = 16'h0815;
            3'd2:    rom = 16'h0A00;
            3'd3:    rom = 16'h0C00;
            3'd4:    rom = 16'h0E42;
            3'd5:    rom = 16'h1019;
            default: rom = 16'h1201;
        endcase
    endfunction

    // 27 slots, MSB first. ACK slots carry a 1 so that oe = ~bit releases SDA.
    function automatic logic [26:0] frame(input logic [2:0] c);
        logic [15:0] w;
        w = rom(c);
        frame = {DEV_ADDR, 1'b0, 1'b1, w[15:8], 1'b1, w[7:0], 1'b1};
    endfunction

    // Pin pattern {scl, oe} for a given position in the transaction.
    function automatic logic [1:0] pins(input state_e st, input logic [1:0] q,
                                        input logic [4:0] s, input logic [2:0] c);
        logic [26:0] fr;
        fr   = frame(c);
        pins = 2'b10;
        case (st)
            S_START: pins = {~q[0], 1'b1};
            S_BIT:   pins = {q[1], ~fr[5'd26 - s]};
            S_STOP:  pins = {q != 2'd0, q != 2'd2};
            default: pins = 2'b10;
        endcase
    endfunction

    assign active = (state_q == S_START) || (state_q == S_BIT) ||
                    (state_q == S_STOP)  || (state_q == S_GAP);
    assign tick   = active && (div_q == 12'(CLK_DIV - 1));

`ifdef WM8731_CFG_ACK_CHECK_EN
    localparam int RW = (MAX_RETRY < 1) ? 1 : $clog2(MAX_RETRY + 1);

    logic [RW-1:0] retry_q, retry_d;
    logic          nack_q, nack_d;
    logic          sda_s1_q, sda_s2_q;

    function automatic logic is_ack(input logic [4:0] s);
        is_ack = (s == 5'd8) || (s == 5'd17) || (s == 5'd26);
    endfunction

    // Bus idles high, so the synchroniser resets to 1.
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            sda_s1_q <= 1'b1;
            sda_s2_q <= 1'b1;
            retry_q  <= '0;
            nack_q   <= 1'b0;
        end else begin
            sda_s1_q <= i2c_sda_in;
            sda_s2_q <= sda_s1_q;
            retry_q  <= retry_d;
            nack_q   <= nack_d;
        end
    end

    assign acked     = ~nack_q;
    assign ack_error = (state_q == S_ERROR);
`else
    localparam int unsigned unused_max_retry = MAX_RETRY;
    logic unused_sda;
    assign unused_sda = i2c_sda_in;
    assign acked      = 1'b1;
    assign ack_error  = 1'b0;
`endif

    always_comb begin
        state_d = state_q;
        qtr_d   = qtr_q;
        slot_d  = slot_q;
        cmd_d   = cmd_q;
        div_d   = '0;
`ifdef WM8731_CFG_ACK_CHECK_EN
        retry_d = retry_q;
        nack_d  = nack_q;
`endif
        if (active) div_d = tick ? 12'd0 : div_q + 12'd1;

        case (state_q)
            S_START: if (tick) begin
                qtr_d = qtr_q + 2'd1;
                if (qtr_q == 2'd1) begin
                    state_d = S_BIT;
                    qtr_d   = '0;
                    slot_d  = '0;
                end
            end
            S_BIT: if (tick) begin
`ifdef WM8731_CFG_ACK_CHECK_EN
                // NACK is only latched here; the frame still runs to STOP.
                if (qtr_q == 2'd2 && is_ack(slot_q) && sda_s2_q) nack_d = 1'b1;
`endif
                qtr_d = qtr_q + 2'd1;
                if (qtr_q == 2'd3) begin
                    if (slot_q == 5'd26) state_d = S_STOP;
                    else                 slot_d  = slot_q + 5'd1;
                end
            end
            S_STOP: if (tick) begin
                qtr_d = qtr_q + 2'd1;
                if (qtr_q == 2'd2) begin
                    state_d = S_GAP;
                    qtr_d   = '0;
                end
            end
            S_GAP: if (tick) begin
                qtr_d = qtr_q + 2'd1;
                if (qtr_q == 2'd3) begin
`ifdef WM8731_CFG_ACK_CHECK_EN
                    nack_d = 1'b0;
`endif
                    if (acked) begin
`ifdef WM8731_CFG_ACK_CHECK_EN
                        retry_d = '0;
`endif
                        if (cmd_q == 3'd6) begin
                            state_d = S_DONE;
                        end else begin
                            cmd_d   = cmd_q + 3'd1;
                            state_d = S_START;
                        end
                    end
`ifdef WM8731_CFG_ACK_CHECK_EN
                    else if (retry_q < RW'(MAX_RETRY)) begin
                        retry_d = retry_q + 1'b1;
                        state_d = S_START;
                    end else begin
                        state_d = S_ERROR;
                    end
`endif
                end
            end
            default: begin
                // IDLE, DONE and ERROR: launch without waiting for a tick.
                if (start) begin
                    state_d = S_START;
                    qtr_d   = '0;
                    slot_d  = '0;
                    cmd_d   = '0;
`ifdef WM8731_CFG_ACK_CHECK_EN
                    retry_d = '0;
                    nack_d  = 1'b0;
`endif
                end
            end
        endcase

        // Pins are registered from the next position so they change glitch-free.
        {sclk_d, oe_d} = pins(state_d, qtr_d, slot_d, cmd_d);
    end

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            state_q <= S_IDLE;
            qtr_q   <= '0;
            slot_q  <= '0;
            cmd_q   <= '0;
            div_q   <= '0;
            sclk_q  <= 1'b1;
            oe_q    <= 1'b0;
        end else begin
            state_q <= state_d;
            qtr_q   <= qtr_d;
            slot_q  <= slot_d;
            cmd_q   <= cmd_d;
            div_q   <= div_d;
            sclk_q  <= sclk_d;
            oe_q    <= oe_d;
        end
    end

    assign i2c_sclk   = sclk_q;
    assign i2c_sda_oe = oe_q;
    assign busy       = active;
    assign done       = (state_q == S_DONE);
    assign cmd_idx    = cmd_q;

endmodule
